// File: rtl/ws_generator_pkg.sv
// Shared I2S definitions: operating parameters, channel state encodings,
// word sizes and the word-select level helper used by the master WS source.
package ws_generator_pkg;

    typedef enum logic [1:0] {MT, MR, ST, SR} mode_t;

    typedef enum logic [1:0] {I2S, LJ, RJ, PCM} standard_t;

    typedef enum logic {f16bits, f32bits} frame_size_t;

    // Externally visible channel state
    typedef enum logic [1:0] {IDLE, L, R} ws_state_t;

    // Word channel selector for ws_level()
    typedef enum logic {CH_L, CH_R} chan_t;

    // Internal generator FSM; S_GAP is the mono filler word, reported as IDLE
    typedef enum logic [1:0] {S_IDLE, S_L, S_R, S_GAP} gen_state_t;

    typedef struct packed {
        mode_t       mode;
        standard_t   standard;
        frame_size_t frame_size;
        logic        stereo;
        logic        stop;
    } OP_t;

    localparam int unsigned N16 = 16;
    localparam int unsigned N32 = 32;

    // I2S drives L=0/R=1; every other standard drives L=1/R=0.
    // The idle level is always the R level.
    function automatic logic ws_level(input standard_t std, input chan_t ch);
        if (std == I2S)
            return (ch == CH_R);
        else
            return (ch == CH_L);
    endfunction

endpackage

// File: rtl/ws_generator.sv
// Master-mode word-select generator. Produces ws from the bit clock and
// publishes channel state, slot index and word/frame strobes. All logic
// runs on the falling edge of clk.
module ws_generator
    import ws_generator_pkg::*;
#(
    parameter int unsigned CNT_W = 5
)(
    input  logic             clk,
    input  logic             rst_,
    input  OP_t              OP,
    input  logic             en,
    output logic             ws,
    output ws_state_t        state,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             word_start,
    output logic             frame_done
);

    gen_state_t       r_fsm;
    ws_state_t        r_state;
    logic             r_ws;
    logic [CNT_W-1:0] r_cnt;
    logic             r_word_start;
    logic             r_frame_done;

    // Frame configuration captured at frame start
    standard_t        r_std;
    logic             r_is32;
    logic             r_stereo;

    logic             w_master;
    logic             w_go;
    logic             w_idle_now;
    logic [CNT_W-1:0] w_last;
    logic [CNT_W-1:0] w_pen;
    logic             w_word_end;
    logic             w_frame_end;

    assign w_master    = (OP.mode == MT) || (OP.mode == MR);
    assign w_go        = w_master && en && !OP.stop;
    assign w_idle_now  = ws_level(OP.standard, CH_R);
    assign w_last      = r_is32 ? CNT_W'(N32 - 1) : CNT_W'(N16 - 1);
    assign w_pen       = w_last - 1'b1;
    assign w_word_end  = (r_fsm == S_L) && (r_cnt == w_last);
    // Both the stereo R word and the mono gap close the frame on their last slot
    assign w_frame_end = ((r_fsm == S_R) || (r_fsm == S_GAP)) && (r_cnt == w_last);

    // Single FSM: word sequencing, slot counter and registered outputs
    always_ff @(negedge clk) begin
        if (rst_) begin
            r_fsm        <= S_IDLE;
            r_state      <= IDLE;
            r_ws         <= w_idle_now;
            r_cnt        <= '0;
            r_word_start <= 1'b0;
            r_frame_done <= 1'b0;
            r_std        <= OP.standard;
            r_is32       <= 1'b0;
            r_stereo     <= 1'b0;
        end else begin
            r_word_start <= 1'b0;
            r_frame_done <= 1'b0;
            if (!w_master && (r_fsm != S_IDLE)) begin
                // Leaving master mode aborts the frame without a frame_done
                r_fsm   <= S_IDLE;
                r_state <= IDLE;
                r_ws    <= w_idle_now;
                r_cnt   <= '0;
            end else if ((r_fsm == S_IDLE) || w_frame_end) begin
                if (w_go) begin
                    r_std        <= OP.standard;
                    r_is32       <= (OP.frame_size == f32bits);
                    r_stereo     <= OP.stereo;
                    r_fsm        <= S_L;
                    r_state      <= L;
                    r_ws         <= ws_level(OP.standard, CH_L);
                    r_cnt        <= '0;
                    r_word_start <= 1'b1;
                end else begin
                    r_fsm   <= S_IDLE;
                    r_state <= IDLE;
                    r_ws    <= w_idle_now;
                    r_cnt   <= '0;
                end
            end else if (w_word_end) begin
                r_cnt <= '0;
                r_ws  <= ws_level(r_std, CH_R);
                if (r_stereo) begin
                    r_fsm        <= S_R;
                    r_state      <= R;
                    r_word_start <= 1'b1;
                end else begin
                    // Mono: an N-slot gap at the idle level lets a slave see L->IDLE
                    r_fsm   <= S_GAP;
                    r_state <= IDLE;
                end
            end else begin
                r_cnt        <= r_cnt + 1'b1;
                // Registered strobe: raised on the edge that enters the last frame slot
                r_frame_done <= ((r_fsm == S_R) || (r_fsm == S_GAP)) && (r_cnt == w_pen);
            end
        end
    end

    assign ws         = r_ws;
    assign state      = r_state;
    assign bit_cnt    = r_cnt;
    assign word_start = r_word_start;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_ws_generator.sv
// Bench for ws_generator: frame-position reference model plus directed
// literal checks and a randomized run.
module tb_ws_generator;
    import ws_generator_pkg::*;

    logic      clk = 1'b0;
    logic      rst_;
    OP_t       op;
    logic      en;
    logic      ws;
    ws_state_t state;
    logic [4:0] bit_cnt;
    logic      word_start;
    logic      frame_done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    ws_generator #(.CNT_W(5)) dut (
        .clk        (clk),
        .rst_       (rst_),
        .OP         (op),
        .en         (en),
        .ws         (ws),
        .state      (state),
        .bit_cnt    (bit_cnt),
        .word_start (word_start),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: a frame is 2N slots indexed by position p.
    // First half is the L word, second half is R (stereo) or gap (mono).
    logic        m_valid = 1'b0;
    logic        m_act   = 1'b0;
    int unsigned m_p     = 0;
    logic        m_st    = 1'b0;
    logic        m_32    = 1'b0;
    standard_t   m_std   = I2S;
    standard_t   m_idle_std = I2S;

    function automatic logic lvl(input standard_t s, input logic left);
        if (s == I2S) return left ? 1'b0 : 1'b1;
        return left ? 1'b1 : 1'b0;
    endfunction

    always @(negedge clk) begin
        int unsigned n;
        logic master;
        logic go;
        master = (op.mode == MT) || (op.mode == MR);
        go     = master && en && !op.stop;
        n      = m_32 ? 32 : 16;
        if (rst_) begin
            m_act = 1'b0;
            m_32  = 1'b0;
        end else if (m_act && !master) begin
            m_act = 1'b0;
        end else if (!m_act || m_p == 2 * n - 1) begin
            if (go) begin
                m_act = 1'b1;
                m_p   = 0;
                m_st  = op.stereo;
                m_32  = (op.frame_size == f32bits);
                m_std = op.standard;
            end else begin
                m_act = 1'b0;
            end
        end else begin
            m_p = m_p + 1;
        end
        m_idle_std = op.standard;
        m_valid    = 1'b1;
    end

    // Compare process: DUT against the model on every rising edge
    always @(posedge clk) begin
        if (m_valid) begin
            logic        e_ws, e_wst, e_fd;
            ws_state_t   e_st;
            int unsigned e_cnt, n;
            n = m_32 ? 32 : 16;
            if (!m_act) begin
                e_ws = lvl(m_idle_std, 1'b0); e_st = IDLE; e_cnt = 0; e_wst = 0; e_fd = 0;
            end else begin
                e_ws  = lvl(m_std, m_p < n);
                e_st  = (m_p < n) ? L : (m_st ? R : IDLE);
                e_cnt = m_p % n;
                e_wst = (m_p == 0) || (m_st && m_p == n);
                e_fd  = (m_p == 2 * n - 1);
            end
            n_cmp++;
            if (ws !== e_ws || state !== e_st || bit_cnt !== 5'(e_cnt) ||
                word_start !== e_wst || frame_done !== e_fd) begin
                n_err++;
                $display("FAIL model t=%0t: got ws=%0b st=%0d cnt=%0d wst=%0b fd=%0b, want ws=%0b st=%0d cnt=%0d wst=%0b fd=%0b",
                         $time, ws, state, bit_cnt, word_start, frame_done,
                         e_ws, e_st, e_cnt, e_wst, e_fd);
            end
        end
    end

    task automatic cyc(input int unsigned k);
        repeat (k) @(posedge clk);
    endtask

    task automatic check(input string name, input logic xws, input ws_state_t xst,
                         input int unsigned xcnt, input logic xwst, input logic xfd);
        n_cmp++;
        if (ws !== xws || state !== xst || bit_cnt !== 5'(xcnt) ||
            word_start !== xwst || frame_done !== xfd) begin
            n_err++;
            $display("FAIL %s: got ws=%0b st=%0d cnt=%0d wst=%0b fd=%0b, want ws=%0b st=%0d cnt=%0d wst=%0b fd=%0b",
                     name, ws, state, bit_cnt, word_start, frame_done,
                     xws, xst, xcnt, xwst, xfd);
        end
    endtask

    initial begin
        rst_          = 1'b1;
        en            = 1'b0;
        op.mode       = MT;
        op.standard   = I2S;
        op.frame_size = f16bits;
        op.stereo     = 1'b1;
        op.stop       = 1'b0;

        // Reset
        cyc(3);
        check("reset", 1'b1, IDLE, 0, 1'b0, 1'b0);

        // I2S f16 stereo
        rst_ = 1'b0;
        en   = 1'b1;
        cyc(1);
        check("i2s_L0", 1'b0, L, 0, 1'b1, 1'b0);
        cyc(15);
        check("i2s_L15", 1'b0, L, 15, 1'b0, 1'b0);
        cyc(1);
        check("i2s_R0", 1'b1, R, 0, 1'b1, 1'b0);
        cyc(15);
        check("i2s_R15", 1'b1, R, 15, 1'b0, 1'b1);
        cyc(1);
        check("i2s_period", 1'b0, L, 0, 1'b1, 1'b0);

        // Mono takes effect at the next frame
        op.stereo = 1'b0;
        cyc(32);
        check("mono_L0", 1'b0, L, 0, 1'b1, 1'b0);
        cyc(16);
        check("mono_gap0", 1'b1, IDLE, 0, 1'b0, 1'b0);
        cyc(15);
        check("mono_gap15", 1'b1, IDLE, 15, 1'b0, 1'b1);
        op.stereo = 1'b1;
        cyc(1);
        check("mono_repeat", 1'b0, L, 0, 1'b1, 1'b0);

        // Stop mid-frame: frame completes, then idle
        cyc(32);
        check("stereo_again", 1'b0, L, 0, 1'b1, 1'b0);
        cyc(3);
        op.stop = 1'b1;
        cyc(28);
        check("stop_R15", 1'b1, R, 15, 1'b0, 1'b1);
        cyc(1);
        check("stop_idle", 1'b1, IDLE, 0, 1'b0, 1'b0);
        cyc(5);
        check("stop_hold", 1'b1, IDLE, 0, 1'b0, 1'b0);
        op.stop = 1'b0;
        cyc(1);
        check("restart", 1'b0, L, 0, 1'b1, 1'b0);

        // Leave master mode mid-R
        cyc(23);
        check("R7", 1'b1, R, 7, 1'b0, 1'b0);
        op.mode = SR;
        cyc(1);
        check("abort", 1'b1, IDLE, 0, 1'b0, 1'b0);
        op.mode = MT;
        cyc(1);
        check("abort_restart", 1'b0, L, 0, 1'b1, 1'b0);

        // Reset mid-word
        cyc(5);
        rst_ = 1'b1;
        cyc(1);
        check("rst_mid", 1'b1, IDLE, 0, 1'b0, 1'b0);
        rst_ = 1'b0;
        cyc(1);
        check("rst_restart", 1'b0, L, 0, 1'b1, 1'b0);

        // Left-justified f32 stereo from the next frame
        op.standard   = LJ;
        op.frame_size = f32bits;
        cyc(32);
        check("lj_L0", 1'b1, L, 0, 1'b1, 1'b0);
        cyc(32);
        check("lj_R0", 1'b0, R, 0, 1'b1, 1'b0);
        cyc(31);
        check("lj_R31", 1'b0, R, 31, 1'b0, 1'b1);

        // Randomized run against the model
        for (int unsigned i = 0; i < 6000; i++) begin
            cyc(1);
            rst_ = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0)
                op.mode = ($urandom_range(0, 9) < 7) ? mode_t'(2'($urandom_range(0, 1)))
                                                     : mode_t'(2'($urandom_range(2, 3)));
            if ($urandom_range(0, 79) == 0) en = ~en;
            if ($urandom_range(0, 79) == 0) op.stop = ~op.stop;
            if ($urandom_range(0, 9) == 0) op.standard = standard_t'(2'($urandom_range(0, 3)));
            if ($urandom_range(0, 9) == 0) op.frame_size = frame_size_t'(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 9) == 0) op.stereo = 1'($urandom_range(0, 1));
        end

        cyc(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
